// File: rtl/unshift_unit_if.sv
// Handshake and data bundle between the controller FSM and the unshift unit.
interface unshift_unit_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = 4
);
    logic             start;
    logic [WIDTH-1:0] in;
    logic [1:0]       shift;
    logic [CNTW-1:0]  amount;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sout;

    modport master (output start, in, shift, amount, input busy, done, sout);
    modport slave  (input start, in, shift, amount, output busy, done, sout);
endinterface

// File: rtl/unshift_unit.sv
// Multi-cycle inverse shifter: undoes a datapath shift code one bit per clock,
// with a start/busy/done handshake.
module unshift_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = 4
) (
    input  logic         clk,
    input  logic         reset,
    unshift_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] work, work_n;
    logic [CNTW-1:0]  cnt, cnt_n;
    logic [1:0]       op, op_n;
    logic [WIDTH-1:0] sout, sout_n;
    logic [WIDTH-1:0] stepped;

    // One inverse step: 01 undoes a left shift, 10 a right shift, 11 a rotate-right.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] w, input logic [1:0] code);
        logic [WIDTH-1:0] r;
        r = w;
        case (code)
            2'b01:   r = {1'b0, w[WIDTH-1:1]};
            2'b10:   r = {w[WIDTH-2:0], 1'b0};
            2'b11:   r = {w[WIDTH-2:0], w[WIDTH-1]};
            default: r = w;
        endcase
        return r;
    endfunction

    assign stepped = step(work, op);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            op    <= '0;
            sout  <= '0;
        end else begin
            state <= state_n;
            work  <= work_n;
            cnt   <= cnt_n;
            op    <= op_n;
            sout  <= sout_n;
        end
    end

    always_comb begin
        state_n = state;
        work_n  = work;
        cnt_n   = cnt;
        op_n    = op;
        sout_n  = sout;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    work_n = bus.in;
                    op_n   = bus.shift;
                    cnt_n  = bus.amount;
                    if (bus.amount == '0 || bus.shift == 2'b00) begin
                        sout_n  = bus.in;
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                work_n = stepped;
                cnt_n  = cnt - CNTW'(1);
                if (cnt == CNTW'(1)) begin
                    sout_n  = stepped;
                    state_n = DONE;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.sout = sout;
endmodule

// File: tb/tb_unshift_unit.sv
// Self-checking bench for unshift_unit: directed cases plus random ops
// against an arithmetic reference model.
module tb_unshift_unit;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [15:0] last_exp;

    unshift_unit_if #(.WIDTH(16), .CNTW(4)) bus ();

    unshift_unit #(.WIDTH(16), .CNTW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-operation result from the shift rules, not by stepping.
    function automatic logic [15:0] ref_unshift(input logic [15:0] x, input logic [1:0] code, input int n);
        logic [31:0] t;
        int r;
        t = {16'h0, x};
        case (code)
            2'b01:   t = t >> n;
            2'b10:   t = t << n;
            2'b11: begin
                r = n % 16;
                if (r != 0) t = (t << r) | (t >> (16 - r));
            end
            default: t = t;
        endcase
        return t[15:0];
    endfunction

    function automatic int ref_latency(input logic [1:0] code, input int n);
        return (n == 0 || code == 2'b00) ? 1 : n + 1;
    endfunction

    task automatic run_op(input string tag, input logic [15:0] x, input logic [1:0] code, input logic [3:0] n);
        int lat;
        int busy_cnt;
        int cycles;
        bit seen;
        logic [15:0] exp;
        exp = ref_unshift(x, code, int'(n));
        lat = ref_latency(code, int'(n));
        for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
        bus.in = x; bus.shift = code; bus.amount = n; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.in = 16'($urandom); bus.shift = 2'($urandom); bus.amount = 4'($urandom);
        busy_cnt = 0; cycles = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.busy) busy_cnt++;
            if (bus.done) seen = 1;
            else if (cycles == 1) check({tag, "_hold"}, bus.sout, last_exp);
        end
        check({tag, "_done"}, seen, 1);
        check({tag, "_lat"}, cycles, lat);
        check({tag, "_busy"}, busy_cnt, lat);
        check({tag, "_sout"}, bus.sout, exp);
        last_exp = exp;
        @(negedge clk);
        check({tag, "_idle"}, {bus.busy, bus.done}, 2'b00);
    endtask

    initial begin
        bit seen;
        n_tests = 0; n_fail = 0; last_exp = '0;
        bus.start = 0; bus.in = '0; bus.shift = '0; bus.amount = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_state", {bus.busy, bus.done, bus.sout}, 18'h0);
        reset = 1'b0;
        @(negedge clk);

        run_op("lsh3",   16'h8000, 2'b01, 4'd3);
        run_op("rsh15",  16'h0001, 2'b10, 4'd15);
        run_op("rsh4",   16'hFFFF, 2'b10, 4'd4);
        run_op("rot1",   16'h8001, 2'b11, 4'd1);
        run_op("rot4",   16'hF00F, 2'b11, 4'd4);
        run_op("rtrip",  16'h891A, 2'b11, 4'd1);
        check("rtrip_orig", bus.sout, 16'h1235);
        run_op("pass7",  16'hABCD, 2'b00, 4'd7);
        run_op("amt0",   16'hABCD, 2'b01, 4'd0);

        // Start held high: inputs changed during RUN are ignored, next op follows in IDLE.
        bus.in = 16'h0F00; bus.shift = 2'b01; bus.amount = 4'd2; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.in = 16'hFFFF;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        check("hs1_done", seen, 1);
        check("hs1_sout", bus.sout, 16'h03C0);
        @(negedge clk);
        check("hs_gap_idle", bus.busy, 1'b0);
        @(negedge clk);
        check("hs2_busy", bus.busy, 1'b1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.done) seen = 1;
            else @(negedge clk);
        end
        bus.start = 1'b0;
        check("hs2_done", seen, 1);
        check("hs2_sout", bus.sout, 16'h3FFF);
        last_exp = 16'h3FFF;
        @(negedge clk);
        @(negedge clk);

        // Reset in the middle of a RUN.
        bus.in = 16'h1234; bus.shift = 2'b10; bus.amount = 4'd10; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1 check("rst_mid", {bus.busy, bus.done, bus.sout}, 18'h0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        check("rst_no_done", seen, 0);
        last_exp = '0;
        run_op("post_rst", 16'h0001, 2'b10, 4'd2);
        check("post_rst_val", bus.sout, 16'h0004);

        for (int k = 0; k < 30; k++)
            run_op($sformatf("rnd%0d", k), 16'($urandom), 2'($urandom), 4'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
